// File: rtl/npi_write_engine.sv
// npi_write_engine
//   Write-direction frame-buffer copier. Pops 32-bit pixel words from an FSL
//   slave channel, packs word pairs big-endian into 64-bit NPI write beats
//   (first word in the upper half / lower address) and issues fixed-size
//   128-byte NPI write bursts at sequential, 128-byte-aligned addresses.
//   An FSL word with Control=1 sets a new base address. If it arrives in the
//   middle of a burst, the burst is zero-padded and committed first.
//
// Optional feature (macro NPI_WRITE_ENGINE_BURST_ACK_EN):
//   When the macro is defined, every accepted burst address is reported on the
//   FSL master channel, once the channel is not full. When it is undefined,
//   FSL_M_Write and FSL_M_Data are tied to 0.
//
// Ports:
//   Clk, Rst_n                 single clock, synchronous active-low reset
//   XIL_NPI_InitDone           MPMC calibration done; nothing happens before it
//   XIL_NPI_Addr/AddrReq/AddrAck/RNW/Size
//                              NPI address phase; RNW is always 0 (write)
//   XIL_NPI_WrFIFO_Data/BE/Push/AlmostFull/Empty/Flush
//                              NPI write FIFO; BE is always all ones, Flush is 0
//   XIL_NPI_RdModWr            always 0
//   FSL_S_Read/Data/Control/Exists
//                              pixel/base-address input channel
//   FSL_M_Write/Data/Control/Full
//                              burst-completion output channel (optional)
module npi_write_engine #(
  parameter int         C_PI_ADDR_WIDTH = 32,
  parameter int         C_PI_DATA_WIDTH = 64,
  parameter int         C_PI_BE_WIDTH   = 8,
  parameter int         C_BURST_BEATS   = 16,
  parameter logic [3:0] C_NPI_SIZE      = 4'd4
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       XIL_NPI_InitDone,
  output logic [C_PI_ADDR_WIDTH-1:0] XIL_NPI_Addr,
  output logic                       XIL_NPI_AddrReq,
  input  logic                       XIL_NPI_AddrAck,
  output logic                       XIL_NPI_RNW,
  output logic [3:0]                 XIL_NPI_Size,
  output logic [C_PI_DATA_WIDTH-1:0] XIL_NPI_WrFIFO_Data,
  output logic [C_PI_BE_WIDTH-1:0]   XIL_NPI_WrFIFO_BE,
  output logic                       XIL_NPI_WrFIFO_Push,
  input  logic                       XIL_NPI_WrFIFO_AlmostFull,
  input  logic                       XIL_NPI_WrFIFO_Empty,
  output logic                       XIL_NPI_WrFIFO_Flush,
  output logic                       XIL_NPI_RdModWr,
  output logic                       FSL_S_Read,
  input  logic [0:31]                FSL_S_Data,
  input  logic                       FSL_S_Control,
  input  logic                       FSL_S_Exists,
  output logic                       FSL_M_Write,
  output logic [0:31]                FSL_M_Data,
  output logic                       FSL_M_Control,
  input  logic                       FSL_M_Full
);

  localparam int CNT_W = $clog2(C_BURST_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(C_BURST_BEATS - 1);
  localparam logic [C_PI_ADDR_WIDTH-1:0] BURST_BYTES =
    C_PI_ADDR_WIDTH'(C_BURST_BEATS * (C_PI_DATA_WIDTH / 8));

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'd0,
    S_FILL      = 2'd1,
    S_REQ       = 2'd2,
    S_ACK       = 2'd3
  } state_t;

  state_t                     state_q;
  logic [C_PI_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]           beat_cnt_q;
  logic                       half_q;
  logic                       pad_q;
  logic [31:0]                hi_q;
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
  logic [C_PI_ADDR_WIDTH-1:0] ack_addr_q;
`endif

  // FILL-state decode. Read and Push must act on the word the FSL presents in
  // this very cycle, so they are decoded combinationally from registered state.
  logic fill_go;
  logic load_base;
  logic start_pad;
  logic take_data;
  logic pad_push;
  logic push;
  logic last_beat;

  always_comb begin
    fill_go   = (state_q == S_FILL) && !XIL_NPI_WrFIFO_AlmostFull;
    pad_push  = fill_go && pad_q;
    take_data = fill_go && !pad_q && FSL_S_Exists && !FSL_S_Control;
    // A base address only takes effect on a burst boundary; otherwise it stays
    // at the FSL head until the padded burst has been committed.
    load_base = fill_go && !pad_q && FSL_S_Exists && FSL_S_Control &&
                !half_q && (beat_cnt_q == '0);
    start_pad = fill_go && !pad_q && FSL_S_Exists && FSL_S_Control &&
                (half_q || (beat_cnt_q != '0));
    push      = pad_push || (take_data && half_q);
    last_beat = push && (beat_cnt_q == LAST_CNT);
  end

  always_comb begin
    FSL_S_Read          = take_data || load_base;
    XIL_NPI_WrFIFO_Push = push;
    XIL_NPI_WrFIFO_Data = '0;
    if (pad_push) begin
      // Pending high half gets a zero low half; afterwards whole zero beats.
      XIL_NPI_WrFIFO_Data = half_q ? C_PI_DATA_WIDTH'({hi_q, 32'h0}) : '0;
    end else if (push) begin
      XIL_NPI_WrFIFO_Data = C_PI_DATA_WIDTH'({hi_q, FSL_S_Data});
    end
    XIL_NPI_AddrReq      = (state_q == S_REQ);
    XIL_NPI_Size         = (state_q == S_REQ) ? C_NPI_SIZE : 4'd0;
    XIL_NPI_Addr         = addr_q;
    XIL_NPI_RNW          = 1'b0;
    XIL_NPI_WrFIFO_BE    = '1;
    XIL_NPI_WrFIFO_Flush = 1'b0;
    XIL_NPI_RdModWr      = 1'b0;
    FSL_M_Control        = 1'b0;
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
    FSL_M_Write = (state_q == S_ACK) && !FSL_M_Full;
    FSL_M_Data  = FSL_M_Write ? 32'(ack_addr_q) : 32'h0;
`else
    FSL_M_Write = 1'b0;
    FSL_M_Data  = 32'h0;
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= S_WAIT_INIT;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      half_q     <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT_INIT: begin
          if (XIL_NPI_InitDone) state_q <= S_FILL;
        end
        S_FILL: begin
          if (load_base) addr_q <= C_PI_ADDR_WIDTH'({FSL_S_Data[0:24], 7'b0});
          if (start_pad) pad_q <= 1'b1;
          if (take_data && !half_q) begin
            hi_q   <= FSL_S_Data;
            half_q <= 1'b1;
          end
          if (push) begin
            half_q     <= 1'b0;
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
          if (last_beat) state_q <= S_REQ;
        end
        S_REQ: begin
          if (XIL_NPI_AddrAck) begin
            addr_q     <= addr_q + BURST_BYTES;
            beat_cnt_q <= '0;
            pad_q      <= 1'b0;
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
            ack_addr_q <= addr_q;
            state_q    <= S_ACK;
`else
            state_q    <= S_FILL;
`endif
          end
        end
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
        S_ACK: begin
          if (!FSL_M_Full) state_q <= S_FILL;
        end
`endif
        default: state_q <= S_WAIT_INIT;
      endcase
    end
  end

  // Inputs that the engine does not need for its decisions.
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
  logic unused_inputs;
  assign unused_inputs = XIL_NPI_WrFIFO_Empty;
`else
  logic unused_inputs;
  assign unused_inputs = XIL_NPI_WrFIFO_Empty ^ FSL_M_Full;
`endif

endmodule

// File: tb/tb_npi_write_engine.sv
// tb_npi_write_engine
//   Randomised bench for npi_write_engine. FSL words are queued both to a
//   source driver and to a word-list reference model that predicts every burst
//   (address plus sixteen beats); observed bursts are compared on AddrAck.
module tb_npi_write_engine;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        XIL_NPI_InitDone;
  logic [31:0] XIL_NPI_Addr;
  logic        XIL_NPI_AddrReq;
  logic        XIL_NPI_AddrAck;
  logic        XIL_NPI_RNW;
  logic [3:0]  XIL_NPI_Size;
  logic [63:0] XIL_NPI_WrFIFO_Data;
  logic [7:0]  XIL_NPI_WrFIFO_BE;
  logic        XIL_NPI_WrFIFO_Push;
  logic        XIL_NPI_WrFIFO_AlmostFull;
  logic        XIL_NPI_WrFIFO_Empty;
  logic        XIL_NPI_WrFIFO_Flush;
  logic        XIL_NPI_RdModWr;
  logic        FSL_S_Read;
  logic [0:31] FSL_S_Data;
  logic        FSL_S_Control;
  logic        FSL_S_Exists;
  logic        FSL_M_Write;
  logic [0:31] FSL_M_Data;
  logic        FSL_M_Control;
  logic        FSL_M_Full;

  always #5 Clk = ~Clk;

  npi_write_engine dut (
    .Clk                      (Clk),
    .Rst_n                    (Rst_n),
    .XIL_NPI_InitDone         (XIL_NPI_InitDone),
    .XIL_NPI_Addr             (XIL_NPI_Addr),
    .XIL_NPI_AddrReq          (XIL_NPI_AddrReq),
    .XIL_NPI_AddrAck          (XIL_NPI_AddrAck),
    .XIL_NPI_RNW              (XIL_NPI_RNW),
    .XIL_NPI_Size             (XIL_NPI_Size),
    .XIL_NPI_WrFIFO_Data      (XIL_NPI_WrFIFO_Data),
    .XIL_NPI_WrFIFO_BE        (XIL_NPI_WrFIFO_BE),
    .XIL_NPI_WrFIFO_Push      (XIL_NPI_WrFIFO_Push),
    .XIL_NPI_WrFIFO_AlmostFull(XIL_NPI_WrFIFO_AlmostFull),
    .XIL_NPI_WrFIFO_Empty     (XIL_NPI_WrFIFO_Empty),
    .XIL_NPI_WrFIFO_Flush     (XIL_NPI_WrFIFO_Flush),
    .XIL_NPI_RdModWr          (XIL_NPI_RdModWr),
    .FSL_S_Read               (FSL_S_Read),
    .FSL_S_Data               (FSL_S_Data),
    .FSL_S_Control            (FSL_S_Control),
    .FSL_S_Exists             (FSL_S_Exists),
    .FSL_M_Write              (FSL_M_Write),
    .FSL_M_Data               (FSL_M_Data),
    .FSL_M_Control            (FSL_M_Control),
    .FSL_M_Full               (FSL_M_Full)
  );

  int n_vec = 0;
  int n_err = 0;

  // Source queue entries are {control, data}.
  logic [32:0] src_q[$];
  // Reference model state.
  logic [31:0] pend[$];
  logic [31:0] m_base = 32'h0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_beats[$];
  logic [31:0] ack_exp[$];
  // Observation logs.
  logic [63:0] obs_beats[$];
  logic [31:0] acc_addr[$];
  logic [31:0] mlog[$];

  int          cur_beats = 0;
  bit          pop_pend = 0;
  bit          req_prev = 0;
  logic [31:0] req_addr_prev = 32'h0;
  int          exist_pct = 100;
  int          af_pct = 0;
  int          af_force = 0;
  int          ack_min = 0;
  int          ack_max = 0;
  int          cur_delay = 0;
  int          req_age = 0;
  int          full_pct = 0;
  int          full_len = 0;
  int          full_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: 32 data words make one burst at the current base; a
  // control word zero-fills any partial burst, commits it, then sets the base.
  task automatic model_emit();
    exp_addr.push_back(m_base);
    for (int k = 0; k < 16; k++) exp_beats.push_back({pend[2*k], pend[2*k+1]});
    pend.delete();
    m_base = m_base + 32'd128;
  endtask

  task automatic send(input bit ctrl, input logic [31:0] d);
    src_q.push_back({ctrl, d});
    if (!ctrl) begin
      pend.push_back(d);
      if (pend.size() == 32) model_emit();
    end else begin
      if (pend.size() != 0) begin
        while (pend.size() < 32) pend.push_back(32'h0);
        model_emit();
      end
      m_base = d & 32'hFFFF_FF80;
    end
  endtask

  task automatic check_burst();
    logic [31:0] ea;
    logic [63:0] eb;
    int          b0;
    acc_addr.push_back(XIL_NPI_Addr);
    chk("burst_size", 64'(XIL_NPI_Size), 64'd4);
    chk("burst_rnw", 64'(XIL_NPI_RNW), 64'd0);
    chk("burst_len", 64'(cur_beats), 64'd16);
    if (exp_addr.size() == 0) begin
      chk("burst_extra", 64'd1, 64'd0);
    end else begin
      ea = exp_addr.pop_front();
      chk("burst_addr", 64'(XIL_NPI_Addr), 64'(ea));
      b0 = obs_beats.size() - cur_beats;
      for (int k = 0; k < 16; k++) begin
        eb = exp_beats.pop_front();
        if (b0 + k < obs_beats.size()) chk("beat", obs_beats[b0+k], eb);
      end
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
      ack_exp.push_back(ea);
`endif
    end
    full_cnt  = full_len;
    cur_beats = 0;
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic cycle();
    logic [31:0] ma;
    @(negedge Clk);
    pop_pend = 0;
    if (XIL_NPI_WrFIFO_AlmostFull) begin
      chk("af_push", 64'(XIL_NPI_WrFIFO_Push), 64'd0);
      chk("af_read", 64'(FSL_S_Read), 64'd0);
    end
    if (FSL_S_Read) begin
      chk("read_exists", 64'(FSL_S_Exists), 64'd1);
      pop_pend = 1;
    end
    if (XIL_NPI_WrFIFO_Push) begin
      obs_beats.push_back(XIL_NPI_WrFIFO_Data);
      cur_beats++;
    end
    if (XIL_NPI_AddrReq) begin
      if (req_prev) chk("addr_hold", 64'(XIL_NPI_Addr), 64'(req_addr_prev));
      req_prev      = 1;
      req_addr_prev = XIL_NPI_Addr;
      if (XIL_NPI_AddrAck) begin
        check_burst();
        req_prev = 0;
      end
    end else begin
      req_prev = 0;
    end
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
    if (FSL_M_Full) chk("mw_full", 64'(FSL_M_Write), 64'd0);
    if (FSL_M_Write) begin
      mlog.push_back(FSL_M_Data);
      if (ack_exp.size() == 0) begin
        chk("mw_extra", 64'd1, 64'd0);
      end else begin
        ma = ack_exp.pop_front();
        chk("mw_data", 64'(FSL_M_Data), 64'(ma));
      end
    end
`else
    if (FSL_M_Write) chk("mw_off", 64'(FSL_M_Write), 64'd0);
    ma = 32'h0;
`endif
    @(posedge Clk);
    #1;
    if (pop_pend && src_q.size() > 0) void'(src_q.pop_front());
    FSL_S_Exists = (src_q.size() > 0) && (int'($urandom_range(99)) < exist_pct);
    if (src_q.size() > 0) begin
      FSL_S_Control = src_q[0][32];
      FSL_S_Data    = src_q[0][31:0];
    end else begin
      FSL_S_Control = 1'b0;
      FSL_S_Data    = $urandom;
    end
    if (af_force > 0) begin
      XIL_NPI_WrFIFO_AlmostFull = 1'b1;
      af_force--;
    end else begin
      XIL_NPI_WrFIFO_AlmostFull = int'($urandom_range(99)) < af_pct;
    end
    if (XIL_NPI_AddrReq) begin
      if (req_age == 0) cur_delay = int'($urandom_range(ack_max, ack_min));
      req_age++;
      XIL_NPI_AddrAck = (req_age > cur_delay);
    end else begin
      req_age         = 0;
      XIL_NPI_AddrAck = 1'b0;
    end
    if (full_cnt > 0) begin
      FSL_M_Full = 1'b1;
      full_cnt--;
    end else begin
      FSL_M_Full = int'($urandom_range(99)) < full_pct;
    end
  endtask

  task automatic wait_idle(input int budget);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      done = (src_q.size() == 0) && (exp_addr.size() == 0) &&
             (ack_exp.size() == 0) && (req_age == 0);
      if (!done) begin
        cycle();
        n++;
      end
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
    repeat (3) cycle();
  endtask

  initial begin
    Rst_n                     = 1'b0;
    XIL_NPI_InitDone          = 1'b0;
    XIL_NPI_AddrAck           = 1'b0;
    XIL_NPI_WrFIFO_AlmostFull = 1'b0;
    XIL_NPI_WrFIFO_Empty      = 1'b1;
    FSL_S_Data                = 32'h1234_5678;
    FSL_S_Control             = 1'b0;
    FSL_S_Exists              = 1'b1;
    FSL_M_Full                = 1'b0;

    // Reset state.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_read", 64'(FSL_S_Read), 64'd0);
    chk("rst_push", 64'(XIL_NPI_WrFIFO_Push), 64'd0);
    chk("rst_data", XIL_NPI_WrFIFO_Data, 64'd0);
    chk("rst_req", 64'(XIL_NPI_AddrReq), 64'd0);
    chk("rst_addr", 64'(XIL_NPI_Addr), 64'd0);
    chk("rst_size", 64'(XIL_NPI_Size), 64'd0);
    chk("rst_be", 64'(XIL_NPI_WrFIFO_BE), 64'hFF);
    chk("rst_rnw", 64'(XIL_NPI_RNW), 64'd0);
    chk("rst_flush", 64'(XIL_NPI_WrFIFO_Flush), 64'd0);
    chk("rst_rmw", 64'(XIL_NPI_RdModWr), 64'd0);
    chk("rst_mwrite", 64'(FSL_M_Write), 64'd0);
    chk("rst_mdata", 64'(FSL_M_Data), 64'd0);
    chk("rst_mctrl", 64'(FSL_M_Control), 64'd0);

    // Out of reset but calibration not done: nothing may be read.
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      chk("init_read", 64'(FSL_S_Read), 64'd0);
    end
    @(posedge Clk);
    #1;
    FSL_S_Exists     = 1'b0;
    XIL_NPI_InitDone = 1'b1;

    // Base address, then 96 words: three bursts, ack held off 5 cycles.
    ack_min  = 5;
    ack_max  = 5;
    full_len = 4;
    send(1'b1, 32'h0010_0045);
    for (int i = 1; i <= 96; i++) send(1'b0, 32'(i));
    wait_idle(2000);
    chk("b0_addr", 64'(acc_addr[0]), 64'h0010_0000);
    chk("b0_beat0", obs_beats[0], 64'h00000001_00000002);
    chk("b0_beat15", obs_beats[15], 64'h0000001F_00000020);
    chk("b1_addr", 64'(acc_addr[1]), 64'h0010_0080);
    chk("b2_addr", 64'(acc_addr[2]), 64'h0010_0100);
`ifdef NPI_WRITE_ENGINE_BURST_ACK_EN
    chk("m_first", 64'(mlog[0]), 64'h0010_0000);
`endif

    // Base change after three words: padded burst, then the new base.
    full_len = 0;
    ack_min  = 0;
    ack_max  = 2;
    for (int i = 1; i <= 3; i++) send(1'b0, 32'(i));
    send(1'b1, 32'h0020_0000);
    for (int i = 1; i <= 32; i++) send(1'b0, 32'(i + 200));
    wait_idle(2000);
    chk("pad_addr", 64'(acc_addr[3]), 64'h0010_0180);
    chk("pad_beat1", obs_beats[49], 64'h00000003_00000000);
    chk("pad_beat2", obs_beats[50], 64'h0);
    chk("new_base", 64'(acc_addr[4]), 64'h0020_0000);

    // Ten-cycle AlmostFull window in the middle of a fill.
    for (int i = 1; i <= 32; i++) send(1'b0, 32'(i));
    repeat (12) cycle();
    af_force = 10;
    wait_idle(2000);
    chk("af_beat0", obs_beats[80], 64'h00000001_00000002);
    chk("af_beat15", obs_beats[95], 64'h0000001F_00000020);

    // Address wrap at the top of the space.
    send(1'b1, 32'hFFFF_FF80);
    for (int i = 0; i < 64; i++) send(1'b0, $urandom);
    wait_idle(2000);
    chk("n_bursts", 64'(acc_addr.size()), 64'd8);
    chk("wrap_pre", 64'(acc_addr[6]), 64'hFFFF_FF80);
    chk("wrap_addr", 64'(acc_addr[7]), 64'h0);

    // Random mix with bursty FSL, back-pressure and ack jitter.
    exist_pct = 70;
    af_pct    = 20;
    ack_min   = 0;
    ack_max   = 4;
    full_pct  = 30;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 6) send(1'b1, $urandom);
      else send(1'b0, $urandom);
    end
    send(1'b1, 32'h0000_0000);
    wait_idle(20000);
    chk("exp_drained", 64'(exp_beats.size()), 64'd0);
    chk("ack_drained", 64'(ack_exp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/npi_write_engine.md
Name: npi_write_engine

Overview:
- Write-direction counterpart of the frame-buffer read copier.
- Accepts 32-bit pixel words from a MicroBlaze/producer FSL slave channel and packs word pairs into 64-bit NPI beats.
- Writes them to MPMC memory as fixed-size NPI write bursts at sequential, 128-byte-aligned addresses.
- A control-flagged FSL word sets a new base address.

Parameters:
- C_PI_ADDR_WIDTH, 32, NPI address width.
- C_PI_DATA_WIDTH, 64, NPI data width; only 64 is supported.
- C_PI_BE_WIDTH, 8, NPI byte-enable width.
- C_BURST_BEATS, 16, 64-bit beats per burst (128 bytes).
- C_NPI_SIZE, 4'd4, NPI Size code for one 128-byte burst.

Ports:
- Clk  in  1  single clock for FSL and NPI.
- Rst_n  in  1  synchronous active-low reset.
- XIL_NPI_InitDone  in  1  MPMC calibration complete.
- XIL_NPI_Addr  out  32  burst byte address.
- XIL_NPI_AddrReq  out  1  address request.
- XIL_NPI_AddrAck  in  1  address accepted.
- XIL_NPI_RNW  out  1  always 0.
- XIL_NPI_Size  out  4  C_NPI_SIZE while AddrReq is high, else 0.
- XIL_NPI_WrFIFO_Data  out  64  write beat.
- XIL_NPI_WrFIFO_BE  out  8  always 8'hFF.
- XIL_NPI_WrFIFO_Push  out  1  one beat pushed per cycle high.
- XIL_NPI_WrFIFO_AlmostFull  in  1  write FIFO back-pressure.
- XIL_NPI_WrFIFO_Empty  in  1  write FIFO drained.
- XIL_NPI_WrFIFO_Flush  out  1  always 0.
- XIL_NPI_RdModWr  out  1  always 0.
- FSL_S_Read  out  1  pop FSL word.
- FSL_S_Data  in  [0:31]  pixel word, or base address when Control is 1.
- FSL_S_Control  in  1  word is a base address.
- FSL_S_Exists  in  1  FSL word available.
- FSL_M_Write  out  1  completion word valid (optional feature).
- FSL_M_Data  out  [0:31]  committed burst address (optional feature).
- FSL_M_Control  out  1  always 0.
- FSL_M_Full  in  1  FSL master full.

Behaviour:
- Reset (Rst_n=0 at a Clk edge) clears every output to 0, except WrFIFO_BE=8'hFF. Clears state=WAIT_INIT, addr=0, beat_cnt=0, half=0, pad=0.
- Reset mid-burst abandons that burst. Pushed beats are not requested and are left to MPMC; the system resets MPMC together with this block.
- WAIT_INIT: go to FILL when InitDone=1. FSL_S_Read is held 0 until then.
- FILL, data word (Exists=1, Control=0, AlmostFull=0):
  - FSL_S_Read=1 for that cycle.
  - half=0: latch word into the Data[63:32] register, set half=1.
  - half=1: drive Data={hi,word}, Push=1 in the same cycle, clear half, increment beat_cnt.
  - First FSL word goes to the high half (lower address, big-endian).
- FILL, AlmostFull=1: no read and no push. Stall with the state held.
- FILL, control word (Control=1):
  - If half=0 and beat_cnt=0: read it and set addr={Data[0:24],7'b0} (low 7 bits forced to 0). Takes 1 cycle, no burst issued.
  - Otherwise: do not read it. Set pad=1 and push zero-fill (pending half padded with 32'h0, then 64'h0 beats, 1 beat per non-AlmostFull cycle) until beat_cnt=C_BURST_BEATS. The control word is consumed after the burst completes.
- When beat_cnt reaches C_BURST_BEATS, go to REQ.
- REQ: AddrReq=1, RNW=0, Size=C_NPI_SIZE, Addr=addr, all held stable until AddrAck=1. AddrReq drops the cycle after the ack.
- Same-cycle AddrReq/AddrAck counts as accepted.
- On ack: addr+=128 (wraps mod 2^32), beat_cnt=0, pad=0, return to FILL.
- FILL→REQ→FILL minimum turnaround: 2 cycles. Data beats never precede the FIFO space check.
- Control and data words arriving back-to-back are handled in order, with no word lost or duplicated.

Optional Feature:
- Macro: NPI_WRITE_ENGINE_BURST_ACK_EN.
- Defined: on AddrAck, go to ACK instead of FILL. ACK drives FSL_M_Write=1 and FSL_M_Data=acked address for exactly 1 cycle when FSL_M_Full=0, then goes to FILL. ACK stalls while Full=1.
- Undefined: no ACK state; FSL_M_Write and FSL_M_Data tied to 0.

Test Plan:
- Reset then InitDone=1; control word 32'h0010_0045, then 32 data words 1..32 → one burst at Addr=32'h0010_0000, Size=4. Beat0=64'h00000001_00000002, beat15=64'h0000001F_00000020.
- 64 more data words → bursts at 32'h0010_0080 and 32'h0010_0100, each with 16 Push pulses and AddrReq held until AddrAck is delayed by 5 cycles.
- After 3 data words, control word 32'h0020_0000 → beat1=64'h00000003_00000000, 14 zero beats, burst at the old address; the next burst goes to 32'h0020_0000.
- AlmostFull high for 10 cycles mid-fill → no Push and no FSL_S_Read during those cycles; burst data identical to the unstalled run.
- Base 32'hFFFF_FF80, 64 words → second burst Addr=32'h0000_0000 (wrap).
- With the macro defined and FSL_M_Full high for 4 cycles → FSL_M_Write pulses once after Full drops, with data=32'h0010_0000.
